// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing for the 5-stage RV32I core: load-use bubbles, redirect flushes and data-memory freeze.
// Define HAZARD_PERF_CNT_EN to add saturating stall / flush / memory-wait performance counters.
module hazard_stall_controller #(
    parameter int LOAD_BUBBLES = 1,
    parameter int FLUSH_EXTRA  = 0
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ip_IF_ID_RegisterRS1,
    input  logic [4:0] ip_IF_ID_RegisterRS2,
    input  logic       ip_Use_RS1,
    input  logic       ip_Use_RS2,
    input  logic [4:0] ip_ID_EX_RegisterRD,
    input  logic       ip_ID_EX_MemRead,
    input  logic       ip_EX_Redirect,
    input  logic       ip_EX_MEM_MemAccess,
    input  logic       ip_DMem_Ready,
    output logic       op_PCWrite,
    output logic       op_PC_Sel,
    output logic       op_IF_ID_Write,
    output logic       op_IF_ID_Flush,
    output logic       op_ID_EX_Flush,
    output logic       op_Pipe_Freeze,
    output logic       op_MEM_WB_Bubble,
    output logic       op_Stall_Busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] op_Stall_Cycles,
    output logic [CNT_W-1:0] op_Flush_Events,
    output logic [CNT_W-1:0] op_MemWait_Cycles
`endif
);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_LU_BUBBLE = 2'd1,
        S_FLUSH     = 2'd2,
        S_MEM_WAIT  = 2'd3
    } state_t;

    // The first load-use bubble is issued from S_RUN, so S_LU_BUBBLE covers the remaining ones.
    localparam logic [1:0] LU_CNT_INIT = (LOAD_BUBBLES > 1) ? 2'(LOAD_BUBBLES - 2) : 2'd0;
    localparam logic [1:0] FL_CNT_INIT = (FLUSH_EXTRA > 0)  ? 2'(FLUSH_EXTRA - 1)  : 2'd0;

    state_t     state_q, state_d;
    state_t     ret_q, ret_d;
    logic [1:0] cnt_q, cnt_d;
    logic       lu;
    logic       mw;

    always_comb begin
        lu = 1'b0;
        mw = 1'b0;
        if (ip_ID_EX_MemRead && (ip_ID_EX_RegisterRD != 5'd0)) begin
            lu = (ip_Use_RS1 && (ip_ID_EX_RegisterRD == ip_IF_ID_RegisterRS1)) ||
                 (ip_Use_RS2 && (ip_ID_EX_RegisterRD == ip_IF_ID_RegisterRS2));
        end
        mw = ip_EX_MEM_MemAccess && !ip_DMem_Ready;
    end

    always_comb begin
        state_d          = state_q;
        ret_d            = ret_q;
        cnt_d            = cnt_q;
        op_PCWrite       = 1'b1;
        op_PC_Sel        = 1'b0;
        op_IF_ID_Write   = 1'b1;
        op_IF_ID_Flush   = 1'b0;
        op_ID_EX_Flush   = 1'b0;
        op_Pipe_Freeze   = 1'b0;
        op_MEM_WB_Bubble = 1'b0;
        op_Stall_Busy    = (state_q != S_RUN);

        if (rst) begin
            state_d          = S_RUN;
            ret_d            = S_RUN;
            cnt_d            = 2'd0;
            op_PCWrite       = 1'b0;
            op_IF_ID_Write   = 1'b0;
            op_IF_ID_Flush   = 1'b1;
            op_ID_EX_Flush   = 1'b1;
            op_MEM_WB_Bubble = 1'b1;
            op_Stall_Busy    = 1'b0;
        end else if (mw) begin
            // Whole pipeline holds; cnt is untouched so the interrupted sequence resumes intact.
            op_PCWrite       = 1'b0;
            op_IF_ID_Write   = 1'b0;
            op_Pipe_Freeze   = 1'b1;
            op_MEM_WB_Bubble = 1'b1;
            if (state_q != S_MEM_WAIT) begin
                ret_d   = state_q;
                state_d = S_MEM_WAIT;
            end
        end else if (state_q == S_MEM_WAIT) begin
            state_d = ret_q;
        end else if (ip_EX_Redirect) begin
            op_PC_Sel      = 1'b1;
            op_IF_ID_Flush = 1'b1;
            op_ID_EX_Flush = 1'b1;
            if (FLUSH_EXTRA > 0) begin
                cnt_d   = FL_CNT_INIT;
                state_d = S_FLUSH;
            end else begin
                cnt_d   = 2'd0;
                state_d = S_RUN;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (lu) begin
                        op_PCWrite     = 1'b0;
                        op_IF_ID_Write = 1'b0;
                        op_ID_EX_Flush = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            cnt_d   = LU_CNT_INIT;
                            state_d = S_LU_BUBBLE;
                        end
                    end
                end
                S_LU_BUBBLE: begin
                    op_PCWrite     = 1'b0;
                    op_IF_ID_Write = 1'b0;
                    op_ID_EX_Flush = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                S_FLUSH: begin
                    // ID holds a NOP here, so a load-use match is meaningless and ignored.
                    op_IF_ID_Flush = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            ret_q   <= S_RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] mwait_cnt_q, mwait_cnt_d;

    // A load-use stall is the only case with an ID/EX bubble but no IF/ID flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mwait_cnt_d = mwait_cnt_q;
        if (op_ID_EX_Flush && !op_IF_ID_Flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (op_PC_Sel && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (op_Pipe_Freeze && (mwait_cnt_q != '1)) begin
            mwait_cnt_d = mwait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mwait_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mwait_cnt_q <= mwait_cnt_d;
        end
    end

    assign op_Stall_Cycles   = stall_cnt_q;
    assign op_Flush_Events   = flush_cnt_q;
    assign op_MemWait_Cycles = mwait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: three instances (LOAD_BUBBLES/FLUSH_EXTRA = 1/0, 2/2, 3/3) on shared inputs.
// Output vector order: {PCWrite, PC_Sel, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze, MEM_WB_Bubble, Stall_Busy}.
module tb_hazard_stall_controller;

    localparam logic [7:0] O_RST   = 8'b0001_1010;
    localparam logic [7:0] O_DEF   = 8'b1010_0000;
    localparam logic [7:0] O_DEF_B = 8'b1010_0001;
    localparam logic [7:0] O_STL   = 8'b0000_1000;
    localparam logic [7:0] O_STL_B = 8'b0000_1001;
    localparam logic [7:0] O_RED   = 8'b1111_1000;
    localparam logic [7:0] O_RED_B = 8'b1111_1001;
    localparam logic [7:0] O_FLS   = 8'b1011_0001;
    localparam logic [7:0] O_FRZ   = 8'b0000_0110;
    localparam logic [7:0] O_FRZ_B = 8'b0000_0111;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic use1 = 0, use2 = 0, mr = 0, redir = 0, macc = 0, rdy = 1;

    int n_checks = 0;
    int n_fail   = 0;

    wire [7:0]  out_v [3];
    wire [31:0] pc_stall [3];
    wire [31:0] pc_flush [3];
    wire [31:0] pc_mw [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        logic pcw, pcs, ifw, iff_o, idf, frz, mwb, bsy;
        hazard_stall_controller #(
            .LOAD_BUBBLES(k + 1),
            .FLUSH_EXTRA ((k == 0) ? 0 : k + 1)
        ) u_dut (
            .clk                 (clk),
            .rst                 (rst),
            .ip_IF_ID_RegisterRS1(rs1),
            .ip_IF_ID_RegisterRS2(rs2),
            .ip_Use_RS1          (use1),
            .ip_Use_RS2          (use2),
            .ip_ID_EX_RegisterRD (rd),
            .ip_ID_EX_MemRead    (mr),
            .ip_EX_Redirect      (redir),
            .ip_EX_MEM_MemAccess (macc),
            .ip_DMem_Ready       (rdy),
            .op_PCWrite          (pcw),
            .op_PC_Sel           (pcs),
            .op_IF_ID_Write      (ifw),
            .op_IF_ID_Flush      (iff_o),
            .op_ID_EX_Flush      (idf),
            .op_Pipe_Freeze      (frz),
            .op_MEM_WB_Bubble    (mwb),
            .op_Stall_Busy       (bsy)
`ifdef HAZARD_PERF_CNT_EN
            ,
            .op_Stall_Cycles     (pc_stall[k]),
            .op_Flush_Events     (pc_flush[k]),
            .op_MemWait_Cycles   (pc_mw[k])
`endif
        );
        assign out_v[k] = {pcw, pcs, ifw, iff_o, idf, frz, mwb, bsy};
`ifndef HAZARD_PERF_CNT_EN
        assign pc_stall[k] = '0;
        assign pc_flush[k] = '0;
        assign pc_mw[k]    = '0;
`endif
    end

    // behavioural model: remaining bubble / flush cycles and a "was frozen last cycle" flag
    wire lu_in = mr && (rd != 5'd0) && ((use1 && rd == rs1) || (use2 && rd == rs2));
    wire mw_in = macc && !rdy;

    int bub_left [3];
    int flush_left [3];
    bit waiting [3];
    int m_stall [3];
    int m_flush [3];
    int m_mw [3];

    function automatic int lb_of(int k);
        return k + 1;
    endfunction

    function automatic int fe_of(int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    function automatic logic [7:0] exp_out(int k);
        logic busy;
        busy = waiting[k] || (flush_left[k] > 0) || (bub_left[k] > 0);
        if (rst)                 return O_RST;
        if (mw_in)               return {7'b0000_011, busy};
        if (waiting[k])          return O_DEF_B;
        if (redir)               return {7'b1111_100, busy};
        if (flush_left[k] > 0)   return O_FLS;
        if (bub_left[k] > 0)     return O_STL_B;
        if (lu_in)               return O_STL;
        return O_DEF;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                bub_left[k]   <= 0;
                flush_left[k] <= 0;
                waiting[k]    <= 1'b0;
                m_stall[k]    <= 0;
                m_flush[k]    <= 0;
                m_mw[k]       <= 0;
            end else if (mw_in) begin
                waiting[k] <= 1'b1;
                m_mw[k]    <= m_mw[k] + 1;
            end else if (waiting[k]) begin
                waiting[k] <= 1'b0;
            end else if (redir) begin
                flush_left[k] <= fe_of(k);
                bub_left[k]   <= 0;
                m_flush[k]    <= m_flush[k] + 1;
            end else if (flush_left[k] > 0) begin
                flush_left[k] <= flush_left[k] - 1;
            end else if (bub_left[k] > 0) begin
                bub_left[k] <= bub_left[k] - 1;
                m_stall[k]  <= m_stall[k] + 1;
            end else if (lu_in) begin
                bub_left[k] <= lb_of(k) - 1;
                m_stall[k]  <= m_stall[k] + 1;
            end
        end
    end

    // scoreboard compare every cycle, away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (out_v[k] !== exp_out(k)) begin
                n_fail++;
                $display("FAIL outputs dut%0d t=%0t got %b expected %b", k, $time, out_v[k], exp_out(k));
            end
`ifdef HAZARD_PERF_CNT_EN
            n_checks++;
            if ({pc_stall[k], pc_flush[k], pc_mw[k]} !== {32'(m_stall[k]), 32'(m_flush[k]), 32'(m_mw[k])}) begin
                n_fail++;
                $display("FAIL perf dut%0d t=%0t got %0d/%0d/%0d expected %0d/%0d/%0d", k, $time,
                         pc_stall[k], pc_flush[k], pc_mw[k], m_stall[k], m_flush[k], m_mw[k]);
            end
`endif
        end
    end

    // driver tasks
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a_rs1, input logic [4:0] a_rs2, input logic a_u1,
                         input logic a_u2, input logic [4:0] a_rd, input logic a_mr,
                         input logic a_redir, input logic a_macc, input logic a_rdy);
        rs1 = a_rs1; rs2 = a_rs2; use1 = a_u1; use2 = a_u2; rd = a_rd;
        mr = a_mr; redir = a_redir; macc = a_macc; rdy = a_rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        rst = 1'b1; idle();
        smp(); chk("reset a", 32'(out_v[0]), 32'(O_RST)); chk("reset c", 32'(out_v[2]), 32'(O_RST)); nxt();
        nxt();
        rst = 1'b0;
        smp(); chk("idle a", 32'(out_v[0]), 32'(O_DEF)); nxt();

        // load-use on rs1: 1, 2 and 3 bubbles
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        smp(); chk("lu1 a", 32'(out_v[0]), 32'(O_STL)); chk("lu1 c", 32'(out_v[2]), 32'(O_STL)); nxt();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        smp(); chk("lu2 a", 32'(out_v[0]), 32'(O_DEF)); chk("lu2 b", 32'(out_v[1]), 32'(O_STL_B)); nxt();
        smp(); chk("lu3 b", 32'(out_v[1]), 32'(O_DEF)); chk("lu3 c", 32'(out_v[2]), 32'(O_STL_B)); nxt();
        smp(); chk("lu4 c", 32'(out_v[2]), 32'(O_DEF)); nxt();

        // rs2 match ignored without Use_RS2, stalls with it
        drive(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        smp(); chk("rs2 unused b", 32'(out_v[1]), 32'(O_DEF)); nxt();
        drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        smp(); chk("rs2 used b", 32'(out_v[1]), 32'(O_STL)); nxt();
        drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        smp(); chk("rs2 bubble2 b", 32'(out_v[1]), 32'(O_STL_B)); nxt();
        for (int i = 0; i < 3; i++) begin idle(); nxt(); end

        // x0 destination never stalls
        drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        smp(); chk("rd0 a", 32'(out_v[0]), 32'(O_DEF)); chk("rd0 c", 32'(out_v[2]), 32'(O_DEF)); nxt();

        // redirect with 0 / 2 / 3 extra flush cycles
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        smp(); chk("redir a", 32'(out_v[0]), 32'(O_RED)); chk("redir b", 32'(out_v[1]), 32'(O_RED)); nxt();
        idle();
        smp(); chk("flush1 a", 32'(out_v[0]), 32'(O_DEF)); chk("flush1 b", 32'(out_v[1]), 32'(O_FLS)); nxt();
        smp(); chk("flush2 b", 32'(out_v[1]), 32'(O_FLS)); chk("flush2 c", 32'(out_v[2]), 32'(O_FLS)); nxt();
        smp(); chk("flush3 b", 32'(out_v[1]), 32'(O_DEF)); chk("flush3 c", 32'(out_v[2]), 32'(O_FLS)); nxt();
        smp(); chk("flush4 c", 32'(out_v[2]), 32'(O_DEF)); nxt();

        // redirect during the second bubble aborts the bubble sequence
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        smp(); chk("abort lu c", 32'(out_v[2]), 32'(O_STL)); nxt();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        smp(); chk("abort redir c", 32'(out_v[2]), 32'(O_RED_B)); chk("abort redir a", 32'(out_v[0]), 32'(O_RED)); nxt();
        idle();
        smp(); chk("abort flush c", 32'(out_v[2]), 32'(O_FLS)); nxt();
        nxt(); nxt();
        smp(); chk("abort done c", 32'(out_v[2]), 32'(O_DEF)); nxt();

        // memory wait of 3 cycles inside a 3-bubble load-use sequence
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        smp(); chk("mw lu c", 32'(out_v[2]), 32'(O_STL)); nxt();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        smp(); chk("mw first a", 32'(out_v[0]), 32'(O_FRZ)); chk("mw first c", 32'(out_v[2]), 32'(O_FRZ_B)); nxt();
        for (int i = 0; i < 2; i++) begin
            smp(); chk("mw hold c", 32'(out_v[2]), 32'(O_FRZ_B)); nxt();
        end
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        smp(); chk("mw exit c", 32'(out_v[2]), 32'(O_DEF_B)); nxt();
        idle();
        smp(); chk("mw resume1 c", 32'(out_v[2]), 32'(O_STL_B)); nxt();
        smp(); chk("mw resume2 c", 32'(out_v[2]), 32'(O_STL_B)); nxt();
        smp(); chk("mw done c", 32'(out_v[2]), 32'(O_DEF));
`ifdef HAZARD_PERF_CNT_EN
        chk("memwait cycles c", pc_mw[2], 32'd3);
`endif
        nxt();

        // load-use ignored while flushing; memory wait inside a flush
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        smp(); chk("fl redir b", 32'(out_v[1]), 32'(O_RED)); nxt();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        smp(); chk("fl lu ignored b", 32'(out_v[1]), 32'(O_FLS)); nxt();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        smp(); chk("fl freeze b", 32'(out_v[1]), 32'(O_FRZ_B)); nxt();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        smp(); chk("fl wait exit b", 32'(out_v[1]), 32'(O_DEF_B)); nxt();
        smp(); chk("fl resume b", 32'(out_v[1]), 32'(O_FLS)); nxt();
        idle();
        smp(); chk("fl done b", 32'(out_v[1]), 32'(O_DEF)); nxt();
        for (int i = 0; i < 3; i++) begin idle(); nxt(); end

        // reset asserted in the middle of a memory wait
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        nxt();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        nxt(); nxt();
        rst = 1'b1;
        smp(); chk("rst mid-wait c", 32'(out_v[2]), 32'(O_RST)); nxt();
        rst = 1'b0; idle();
        smp(); chk("after rst c", 32'(out_v[2]), 32'(O_DEF)); chk("after rst b", 32'(out_v[1]), 32'(O_DEF)); nxt();
        idle(); nxt();

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
